// File: rtl/rs_enc_frame_ctrl_if.sv
// Valid/ready symbol stream used on the input and output sides of the RS(255,223) frame controller.
interface rs_enc_frame_ctrl_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rs_enc_frame_ctrl.sv
// Frame sequencer for the RS(255,223) LFSR encoder core: K data beats in, N symbols out.
// Optional statistics counters (frame_cnt, abort_cnt) are built when RS_ENC_STATS_EN is defined.
module rs_enc_frame_ctrl #(
    parameter int N = 255,
    parameter int K = 223,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    rs_enc_frame_ctrl_if.slave    s,
    rs_enc_frame_ctrl_if.master   m,
    input  logic                  abort,
    output logic                  m_first,
    output logic                  m_last,
    output logic [W-1:0]          enc_data,
    output logic                  enc_fb_en,
    output logic                  enc_shift,
    output logic                  enc_clear,
    input  logic [W-1:0]          enc_parity,
    output logic                  busy
`ifdef RS_ENC_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            abort_cnt
`endif
);
    localparam int         NPAR      = N - K;
    localparam logic [7:0] DATA_LAST = 8'(K - 1);
    localparam logic [7:0] PAR_LAST  = 8'(NPAR - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t     state;
    logic [7:0] sym_cnt;
    logic       out_free;
    logic       accept;
    logic       par_load;

    assign out_free  = !m.valid | m.ready;
    assign s.ready   = (state != PARITY) & out_free & !abort;
    assign accept    = s.valid & s.ready;
    assign par_load  = (state == PARITY) & out_free & !abort;
    assign enc_shift = accept | par_load;
    assign enc_fb_en = (state != PARITY);
    assign enc_clear = abort;
    assign enc_data  = s.data;
    assign busy      = (state != IDLE);

    // Parity beats drain the core with zero feedback, leaving it cleared for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sym_cnt <= '0;
            m.valid <= 1'b0;
            m.data  <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            sym_cnt <= '0;
            m.valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
        end else if (state == PARITY) begin
            if (out_free) begin
                m.data  <= enc_parity;
                m.valid <= 1'b1;
                m_first <= 1'b0;
                m_last  <= (sym_cnt == PAR_LAST);
                if (sym_cnt == PAR_LAST) begin
                    state   <= IDLE;
                    sym_cnt <= '0;
                end else begin
                    sym_cnt <= sym_cnt + 8'd1;
                end
            end
        end else if (accept) begin
            m.data  <= s.data;
            m.valid <= 1'b1;
            m_first <= (state == IDLE);
            m_last  <= 1'b0;
            if (state == IDLE) begin
                state   <= DATA;
                sym_cnt <= 8'd1;
            end else if (sym_cnt == DATA_LAST) begin
                state   <= PARITY;
                sym_cnt <= '0;
            end else begin
                sym_cnt <= sym_cnt + 8'd1;
            end
        end else if (m.ready) begin
            m.valid <= 1'b0;
        end
    end

`ifdef RS_ENC_STATS_EN
    // A frame is counted once its last parity beat has been taken downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (m.valid && m.ready && m_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (abort && (abort_cnt != 8'hFF)) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
